// File: rtl/unstriping_pkg.sv
// rtl/unstriping_pkg.sv - shared state encoding and lane-select constants for the unstriping path
package unstriping_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    L0   = 2'b01,
    L1   = 2'b10
  } state_t;

  // Lane select values shared by the mux and the striping/unstriping blocks
  localparam logic SEL_LANE0 = 1'b0;
  localparam logic SEL_LANE1 = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear wins over increment; the count holds once it reaches all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/unstriping_ctrl.sv
// rtl/unstriping_ctrl.sv - lane sequencing, output qualification and status for the 2-lane unstriping mux
module unstriping_ctrl
  import unstriping_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             enable,
  input  logic             cnt_clr,
  input  logic             err_clr,
  input  logic             valid_in0,
  input  logic             valid_in1,
  output logic             selector,
  output logic             mux_valid,
  output logic             active,
  output logic             lane_err,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] burst_cnt
);

  state_t state;
  state_t next_state;
  logic   mv_raw;
  logic   err_set;
  logic   burst_end;

  // State register; reset drops any pair that is in flight
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, word qualification, error and burst-close detection
  always_comb begin
    next_state = state;
    mv_raw     = 1'b0;
    err_set    = 1'b0;
    burst_end  = 1'b0;
    case (state)
      IDLE: begin
        mv_raw = enable & valid_in0;
        if (enable && valid_in0) begin
          next_state = L1;
        end else if (enable && valid_in1) begin
          // A burst may only open on lane0
          err_set = 1'b1;
        end
      end
      L1: begin
        // Once lane0 was taken, its partner is serviced even if enable drops
        mv_raw = valid_in1;
        if (valid_in1) begin
          next_state = L0;
        end else begin
          // Odd-length burst: the empty lane1 slot is simply skipped
          next_state = IDLE;
          burst_end  = 1'b1;
        end
      end
      L0: begin
        mv_raw = enable & valid_in0;
        if (enable && valid_in0) begin
          next_state = L1;
        end else begin
          next_state = IDLE;
          burst_end  = 1'b1;
          if (valid_in1 && !valid_in0) begin
            err_set = 1'b1;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign selector  = (state == L1) ? SEL_LANE1 : SEL_LANE0;
  assign active    = (state != IDLE);
  assign mux_valid = mv_raw & ~reset;

  // Sticky misalignment flag; a new error outranks a same-cycle clear
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      lane_err <= 1'b0;
    end else if (err_set) begin
      lane_err <= 1'b1;
    end else if (err_clr) begin
      lane_err <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk   (clk_2f),
    .reset (reset),
    .inc   (mux_valid),
    .clr   (cnt_clr),
    .count (word_cnt)
  );

  sat_counter #(.W(CNT_W)) u_burst_cnt (
    .clk   (clk_2f),
    .reset (reset),
    .inc   (burst_end),
    .clr   (cnt_clr),
    .count (burst_cnt)
  );

endmodule

// File: tb/tb_unstriping_ctrl.sv
// tb/tb_unstriping_ctrl.sv - scoreboard bench for unstriping_ctrl
module tb_unstriping_ctrl;

  logic        clk_2f;
  logic        reset;
  logic        enable;
  logic        cnt_clr;
  logic        err_clr;
  logic        valid_in0;
  logic        valid_in1;
  logic        selector;
  logic        mux_valid;
  logic        active;
  logic        lane_err;
  logic [15:0] word_cnt;
  logic [15:0] burst_cnt;
  logic        s_selector;
  logic        s_mux_valid;
  logic        s_active;
  logic        s_lane_err;
  logic [2:0]  s_word_cnt;
  logic [2:0]  s_burst_cnt;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  unstriping_ctrl #(.CNT_W(16)) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .enable    (enable),
    .cnt_clr   (cnt_clr),
    .err_clr   (err_clr),
    .valid_in0 (valid_in0),
    .valid_in1 (valid_in1),
    .selector  (selector),
    .mux_valid (mux_valid),
    .active    (active),
    .lane_err  (lane_err),
    .word_cnt  (word_cnt),
    .burst_cnt (burst_cnt)
  );

  unstriping_ctrl #(.CNT_W(3)) dut_sat (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .enable    (enable),
    .cnt_clr   (cnt_clr),
    .err_clr   (err_clr),
    .valid_in0 (valid_in0),
    .valid_in1 (valid_in1),
    .selector  (s_selector),
    .mux_valid (s_mux_valid),
    .active    (s_active),
    .lane_err  (s_lane_err),
    .word_cnt  (s_word_cnt),
    .burst_cnt (s_burst_cnt)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clk_2f cycle of stimulus; a qualified word pushes its expected lane
  task automatic step(input logic en, input logic v0, input logic v1,
                      input logic cc, input logic ec,
                      input logic exp_mv, input logic exp_sel);
    @(posedge clk_2f);
    #1;
    enable    = en;
    valid_in0 = v0;
    valid_in1 = v1;
    cnt_clr   = cc;
    err_clr   = ec;
    if (exp_mv) exp_q.push_back(exp_sel);
  endtask

  // Monitor: every qualified word must match the next expected lane
  always @(negedge clk_2f) begin
    if (!reset && mux_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word actual_sel=%0d required=no_word", selector);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (selector !== e) begin
          errors++;
          $display("FAIL word_sel actual=%0d required=%0d", selector, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    enable = 1'b1; valid_in0 = 1'b1; valid_in1 = 1'b1;
    cnt_clr = 1'b0; err_clr = 1'b0;

    // Reset: mux_valid forced low even with enable & valid_in0
    repeat (2) @(negedge clk_2f);
    chk("rst_mux_valid", mux_valid, 0);
    chk("rst_selector", selector, 0);
    chk("rst_active", active, 0);
    @(posedge clk_2f); #1;
    enable = 0; valid_in0 = 0; valid_in1 = 0;
    reset = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk_2f);
      chk("idle_sel", selector, 0);
      chk("idle_mv", mux_valid, 0);
      chk("idle_active", active, 0);
      chk("idle_word", word_cnt, 0);
      chk("idle_burst", burst_cnt, 0);
    end

    // Even burst of 8 words
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, 1, (i % 2) == 1);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("even_in_l0", active, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("even_idle", active, 0);
    chk("even_word", word_cnt, 8);
    chk("even_burst", burst_cnt, 1);

    // Odd burst of 5 words: lane1 valid stops one clk_f early
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 1, 1);
    step(1, 1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("odd_skip_sel", selector, 1);
    chk("odd_skip_mv", mux_valid, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("odd_word", word_cnt, 5);
    chk("odd_burst", burst_cnt, 1);
    chk("odd_err", lane_err, 0);
    chk("odd_active", active, 0);

    // Misalignment in IDLE, sticky, then cleared
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("mis_set", lane_err, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("mis_sticky", lane_err, 1);
    step(1, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("mis_set_beats_clr", lane_err, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("mis_cleared", lane_err, 0);

    // Misalignment in L0 closes the burst with an error
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 1, 1);
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("l0mis_err", lane_err, 1);
    chk("l0mis_burst", burst_cnt, 1);
    chk("l0mis_word", word_cnt, 2);
    chk("l0mis_active", active, 0);
    step(0, 0, 0, 1, 1, 0, 0);

    // Enable dropped in L1: lane1 word still serviced, then IDLE
    step(1, 1, 1, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("en_word", word_cnt, 2);
    chk("en_burst", burst_cnt, 1);
    chk("en_active", active, 0);
    chk("en_err", lane_err, 0);

    // Reset asserted in L1 acts immediately
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0);
    @(posedge clk_2f); #1;
    chk("pre_rst_sel", selector, 1);
    chk("pre_rst_word", word_cnt, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_sel", selector, 0);
    chk("async_word", word_cnt, 0);
    chk("async_active", active, 0);
    chk("async_mv", mux_valid, 0);
    @(posedge clk_2f); #1;
    enable = 0; valid_in0 = 0; valid_in1 = 0;
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("post_rst_active", active, 0);
    chk("post_rst_burst", burst_cnt, 0);

    // 10-word stream: narrow counter saturates at 7
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 1, (i % 2) == 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("sat_word", s_word_cnt, 7);
    chk("wide_word", word_cnt, 10);

    // cnt_clr wins over a same-cycle word
    step(1, 1, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("clr_word", word_cnt, 0);
    chk("clr_sat_word", s_word_cnt, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_2f);
    chk("clr_burst", burst_cnt, 1);

    repeat (2) @(posedge clk_2f);
    chk("words_outstanding", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
